// File: rtl/div_tick_pkg.sv
// div_tick_pkg: shared types and defaults for the div_tick_counter slice.
// Holds the FSM state encoding and the command-priority next-state helper.
package div_tick_pkg;

  localparam int DEFAULT_W   = 16;
  localparam int DEFAULT_MAX = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Command priority is clear > stop > start; start while already running and
  // stop while idle are ignored. Unused encodings fall back to IDLE.
  function automatic state_e next_state(input state_e cur, input logic start,
                                        input logic stop, input logic clear);
    state_e nxt;
    nxt = cur;
    if (clear) begin
      nxt = IDLE;
    end else begin
      case (cur)
        IDLE:    if (start && !stop) nxt = RUN;
        RUN:     if (stop) nxt = HOLD;
        HOLD:    if (start && !stop) nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/div_tick_counter_if.sv
// div_tick_counter_if: divided-clock input, run/stop/clear commands and the
// tick/count/status outputs of div_tick_counter. The master drives commands,
// the slave (the counter) drives status.
interface div_tick_counter_if
  import div_tick_pkg::*;
#(
  parameter int W = DEFAULT_W
);
  logic         div_clk;
  logic         start;
  logic         stop;
  logic         clear;
  logic         tick;
  logic [W-1:0] count;
  logic         running;
  logic         wrap;
  logic         ovf;

  modport master (
    output div_clk, start, stop, clear,
    input  tick, count, running, wrap, ovf
  );

  modport slave (
    input  div_clk, start, stop, clear,
    output tick, count, running, wrap, ovf
  );
endinterface

// File: rtl/tick_edge_det.sv
// tick_edge_det: samples div_clk as a level in the clk_in domain and flags its
// rising edges. rise_o is the combinational edge flag (valid the cycle before
// tick_o); tick_o is the registered one-cycle pulse.
// Build option DIV_TICK_SYNC_EN adds a 2-flop synchronizer ahead of the edge
// detector for a div_clk from an unrelated domain (+2 cycles latency).
module tick_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic div_clk_i,
  output logic rise_o,
  output logic tick_o
);

  logic sample;
  logic s0_q;
  logic s1_q;
  logic tick_q;

`ifdef DIV_TICK_SYNC_EN
  logic sync0_q;
  logic sync1_q;

  // Two-flop synchronizer; reset high like the edge stages so a high div_clk
  // at reset release does not look like a rising edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
    end else begin
      sync0_q <= div_clk_i;
      sync1_q <= sync0_q;
    end
  end

  assign sample = sync1_q;
`else
  assign sample = div_clk_i;
`endif

  assign rise_o = s0_q & ~s1_q;

  // Edge-detect pipeline: s0/s1 reset to 1 to suppress a spurious tick.
  // NOTE: non-blocking assignments let s1_q take the old s0_q, forming a real
  // two-stage shift; blocking here would collapse the stages into one.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      s0_q   <= sample;
      s1_q   <= s0_q;
      tick_q <= rise_o;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/div_tick_counter.sv
// div_tick_counter: counts rising edges of the divided clock from clk_divider
// under start/stop/clear control, giving a modulo-MAX timebase with a wrap
// pulse and a sticky overflow flag. Legal range: 2 <= MAX <= 2**W.
// Build option DIV_TICK_SYNC_EN (see tick_edge_det) adds input synchronization.
module div_tick_counter
  import div_tick_pkg::*;
#(
  parameter int W   = DEFAULT_W,
  parameter int MAX = DEFAULT_MAX
) (
  input  logic              clk_in,
  input  logic              rst,
  div_tick_counter_if.slave bus
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         wrap_q,  wrap_d;
  logic         ovf_q,   ovf_d;
  logic         rise;
  logic         tick;

  tick_edge_det u_edge (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_clk_i (bus.div_clk),
    .rise_o    (rise),
    .tick_o    (tick)
  );

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state from the prioritized commands.
  always_comb begin
    state_d = next_state(state_q, bus.start, bus.stop, bus.clear);
  end

  // Count/wrap/ovf next values. A tick is counted in RUN even when stop
  // arrives the same cycle; clear overrides any coincident tick.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == RUN && rise) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap_d  = 1'b1;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count, wrap and overflow registers; they update on the edge that asserts tick.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.tick    = tick;
  assign bus.count   = count_q;
  assign bus.running = (state_q == RUN);
  assign bus.wrap    = wrap_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_div_tick_counter.sv
// tb_div_tick_counter: two counters (MAX=100 and MAX=4) share one div_clk
// waveform shaped like clk_divider DIV=10 output. Each rising edge pushes the
// expected tick (arrival cycle, count, wrap, ovf, running) into a per-DUT
// queue; a negedge monitor pops and compares whenever a DUT shows a tick.
module tb_div_tick_counter;
  import div_tick_pkg::*;

`ifdef DIV_TICK_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] count;
    logic        wrap;
    logic        ovf;
    logic        running;
  } exp_t;

  logic clk_in;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  state_e st_m[2];
  int     cnt_m[2];
  bit     ovf_m[2];
  int     max_m[2];

  div_tick_counter_if #(.W(16)) bus_a ();
  div_tick_counter_if #(.W(16)) bus_b ();

  div_tick_counter #(.W(16), .MAX(100)) u_a (.clk_in(clk_in), .rst(rst), .bus(bus_a));
  div_tick_counter #(.W(16), .MAX(4))   u_b (.clk_in(clk_in), .rst(rst), .bus(bus_b));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic tk, input logic [15:0] c,
                     input logic w, input logic o, input logic r);
    exp_t e;
    bit   empty;
    if (tk) begin
      empty = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
      if (empty) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tick dut%0d: got tick=1 expected tick=0 (cycle %0d)", d, cyc);
      end else begin
        if (d == 0) e = q_a.pop_front();
        else        e = q_b.pop_front();
        check($sformatf("tick_cycle_dut%0d", d), cyc, e.cyc);
        check($sformatf("tick_count_dut%0d", d), {16'd0, c}, {16'd0, e.count});
        check($sformatf("tick_wrap_dut%0d", d), {31'd0, w}, {31'd0, e.wrap});
        check($sformatf("tick_ovf_dut%0d", d), {31'd0, o}, {31'd0, e.ovf});
        check($sformatf("tick_running_dut%0d", d), {31'd0, r}, {31'd0, e.running});
      end
    end else if (w) begin
      check($sformatf("wrap_without_tick_dut%0d", d), {31'd0, w}, 32'd0);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk_in) begin
    mon(0, bus_a.tick, bus_a.count, bus_a.wrap, bus_a.ovf, bus_a.running);
    mon(1, bus_b.tick, bus_b.count, bus_b.wrap, bus_b.ovf, bus_b.running);
  end

  task automatic model_cmd(input int d, input logic st, input logic sp, input logic cl);
    if (cl) begin
      st_m[d] = IDLE; cnt_m[d] = 0; ovf_m[d] = 0;
    end else if (sp) begin
      if (st_m[d] == RUN) st_m[d] = HOLD;
    end else if (st) begin
      if (st_m[d] != RUN) st_m[d] = RUN;
    end
  endtask

  // One-cycle command pulse on the selected DUTs.
  task automatic cmd(input logic st, input logic sp, input logic cl, input logic [1:0] mask);
    @(negedge clk_in);
    bus_a.start = st & mask[0]; bus_a.stop = sp & mask[0]; bus_a.clear = cl & mask[0];
    bus_b.start = st & mask[1]; bus_b.stop = sp & mask[1]; bus_b.clear = cl & mask[1];
    if (mask[0]) model_cmd(0, st, sp, cl);
    if (mask[1]) model_cmd(1, st, sp, cl);
    @(negedge clk_in);
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.clear = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.clear = 1'b0;
  endtask

  // One div_clk period (5 high, 5 low); clr_mask fires clear on the cycle the
  // tick registers.
  task automatic rise(input logic [1:0] clr_mask);
    exp_t e;
    @(negedge clk_in);
    bus_a.div_clk = 1'b1;
    bus_b.div_clk = 1'b1;
    for (int d = 0; d < 2; d++) begin
      e.wrap = 1'b0;
      if (clr_mask[d]) begin
        st_m[d] = IDLE; cnt_m[d] = 0; ovf_m[d] = 0;
      end else if (st_m[d] == RUN) begin
        if (cnt_m[d] == max_m[d] - 1) begin
          cnt_m[d] = 0; e.wrap = 1'b1; ovf_m[d] = 1;
        end else begin
          cnt_m[d] = cnt_m[d] + 1;
        end
      end
      e.cyc     = cyc + 2 + SL;
      e.count   = 16'(cnt_m[d]);
      e.ovf     = ovf_m[d];
      e.running = (st_m[d] == RUN);
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    for (int i = 1; i < 10; i++) begin
      @(negedge clk_in);
      bus_a.div_clk = (i < 5);
      bus_b.div_clk = (i < 5);
      bus_a.clear   = clr_mask[0] && (i == 1 + SL);
      bus_b.clear   = clr_mask[1] && (i == 1 + SL);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    max_m[0] = 100; max_m[1] = 4;
    for (int d = 0; d < 2; d++) begin
      st_m[d] = IDLE; cnt_m[d] = 0; ovf_m[d] = 0;
    end
    rst = 1'b1;
    bus_a.div_clk = 1'b1; bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.clear = 1'b0;
    bus_b.div_clk = 1'b1; bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.clear = 1'b0;

    // T1: reset with div_clk high, release, no spurious tick.
    repeat (2) @(negedge clk_in);
    check("rst_count_a", {16'd0, bus_a.count}, 32'd0);
    check("rst_running_a", {31'd0, bus_a.running}, 32'd0);
    check("rst_tick_a", {31'd0, bus_a.tick}, 32'd0);
    check("rst_ovf_b", {31'd0, bus_b.ovf}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk_in);
    check("t1_count_a", {16'd0, bus_a.count}, 32'd0);
    check("t1_running_a", {31'd0, bus_a.running}, 32'd0);
    bus_a.div_clk = 1'b0; bus_b.div_clk = 1'b0;
    repeat (5) @(negedge clk_in);

    // T2 (DUT a) and T4 (DUT b, MAX=4): start both, 5 rises.
    cmd(1'b1, 1'b0, 1'b0, 2'b11);
    repeat (5) rise(2'b00);
    check("t2_count_a", {16'd0, bus_a.count}, 32'd5);
    check("t2_running_a", {31'd0, bus_a.running}, 32'd1);
    check("t4_count_b", {16'd0, bus_b.count}, 32'd1);
    check("t4_ovf_sticky_b", {31'd0, bus_b.ovf}, 32'd1);

    // T3: hold at 5 for 3 rises, resume for 2 rises.
    cmd(1'b0, 1'b1, 1'b0, 2'b01);
    repeat (3) rise(2'b00);
    check("t3_hold_count_a", {16'd0, bus_a.count}, 32'd5);
    check("t3_hold_running_a", {31'd0, bus_a.running}, 32'd0);
    cmd(1'b1, 1'b0, 1'b0, 2'b01);
    repeat (2) rise(2'b00);
    check("t3_count_a", {16'd0, bus_a.count}, 32'd7);

    // T5: reach count 3 on both, then clear coincident with a tick.
    cmd(1'b0, 1'b0, 1'b1, 2'b01);
    repeat (2) rise(2'b00);
    cmd(1'b1, 1'b0, 1'b0, 2'b01);
    repeat (3) rise(2'b00);
    check("t5_pre_count_a", {16'd0, bus_a.count}, 32'd3);
    check("t5_pre_count_b", {16'd0, bus_b.count}, 32'd3);
    check("t5_pre_ovf_b", {31'd0, bus_b.ovf}, 32'd1);
    rise(2'b11);
    check("t5_count_a", {16'd0, bus_a.count}, 32'd0);
    check("t5_running_a", {31'd0, bus_a.running}, 32'd0);
    check("t5_count_b", {16'd0, bus_b.count}, 32'd0);
    check("t5_ovf_b", {31'd0, bus_b.ovf}, 32'd0);

    // T6: start&stop together in RUN goes to HOLD.
    cmd(1'b1, 1'b0, 1'b0, 2'b01);
    repeat (2) rise(2'b00);
    cmd(1'b1, 1'b1, 1'b0, 2'b01);
    check("t6_startstop_running_a", {31'd0, bus_a.running}, 32'd0);
    check("t6_startstop_count_a", {16'd0, bus_a.count}, 32'd2);
    cmd(1'b1, 1'b0, 1'b0, 2'b01);
    rise(2'b00);
    check("t6_pre_rst_count_a", {16'd0, bus_a.count}, 32'd3);

    // T6: asynchronous reset mid-count.
    @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count_a", {16'd0, bus_a.count}, 32'd0);
    check("t6_rst_running_a", {31'd0, bus_a.running}, 32'd0);
    check("t6_rst_tick_a", {31'd0, bus_a.tick}, 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      st_m[d] = IDLE; cnt_m[d] = 0; ovf_m[d] = 0;
    end
    rise(2'b00);
    check("t6_idle_count_a", {16'd0, bus_a.count}, 32'd0);
    check("t6_idle_running_a", {31'd0, bus_a.running}, 32'd0);
    cmd(1'b1, 1'b0, 1'b0, 2'b01);
    rise(2'b00);
    check("t6_restart_count_a", {16'd0, bus_a.count}, 32'd1);
    check("t6_restart_running_a", {31'd0, bus_a.running}, 32'd1);

    repeat (4) @(negedge clk_in);
    check("pending_ticks_a", q_a.size(), 32'd0);
    check("pending_ticks_b", q_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
